// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the slide-switch debouncer.
// Optional edge-pulse outputs are enabled with SWITCH_DEBOUNCE_EDGE_EN.
package switch_debouncer_pkg;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

    // 20 ms at 50 MHz
    localparam int DB_DEFAULT_CYCLES = 1000000;
    // Short count so benches can exercise the full accept path quickly
    localparam int DB_SIM_CYCLES     = 4;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, STABLE/PENDING FSM
// and, when SWITCH_DEBOUNCE_EDGE_EN is defined, registered edge pulses.
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic clean_o,
    output logic rose_o,
    output logic fell_o
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          clean_q, clean_d;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          accept;

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // cnt_inc is the number of consecutive differing cycles including this
    // one, so the new level is taken on the cycle that count reaches the limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        accept  = 1'b0;
        cnt_inc = cnt_q + 1'b1;

        case (state_q)
            DB_STABLE: begin
                cnt_d = '0;
                if (sync2_q != clean_q) begin
                    if (cnt_inc == CNT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        state_d = DB_PENDING;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            DB_PENDING: begin
                if (sync2_q == clean_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            clean_d = sync2_q;
            state_d = DB_STABLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic rose_q, rose_d;
    logic fell_q, fell_d;

    // Pulses land on the same edge as the clean level they describe
    always_comb begin
        rose_d = accept &  sync2_q;
        fell_d = accept & ~sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rose_q <= 1'b0;
            fell_q <= 1'b0;
        end else begin
            rose_q <= rose_d;
            fell_q <= fell_d;
        end
    end

    assign rose_o = rose_q;
    assign fell_o = fell_q;
`else
    assign rose_o = 1'b0;
    assign fell_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch bank debouncer: one independent debounce_bit per switch.
// Edge pulses exist only when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [0:WIDTH-1] SW_RAW,
    output logic [0:WIDTH-1] SW_CLEAN,
    output logic [0:WIDTH-1] SW_ROSE,
    output logic [0:WIDTH-1] SW_FELL
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .raw_i   (SW_RAW[i]),
            .clean_o (SW_CLEAN[i]),
            .rose_o  (SW_ROSE[i]),
            .fell_o  (SW_FELL[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised bench for switch_debouncer against a sample-history reference model.
// Honours SWITCH_DEBOUNCE_EDGE_EN for the expected edge pulses.
module tb_switch_debouncer;
    import switch_debouncer_pkg::*;

    localparam int W  = 6;
    localparam int DB = DB_SIM_CYCLES;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef logic [0:W-1] vec_t;

    logic CLOCK_50;
    logic RESET_N;
    vec_t sw_raw;
    vec_t SW_CLEAN, SW_ROSE, SW_FELL;

    int n_vec = 0;
    int n_bad = 0;

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SW_RAW   (sw_raw),
        .SW_CLEAN (SW_CLEAN),
        .SW_ROSE  (SW_ROSE),
        .SW_FELL  (SW_FELL)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: a switch level is accepted once the last DB values
    // seen after the two-sample synchroniser delay all disagree with it.
    vec_t rawq[$];
    vec_t obsq[$];
    vec_t clean_m, rose_m, fell_m;

    function automatic void model_reset();
        rawq.delete();
        rawq.push_back('0);
        rawq.push_back('0);
        obsq.delete();
        clean_m = '0;
        rose_m  = '0;
        fell_m  = '0;
    endfunction

    function automatic void model_edge();
        vec_t obs;
        bit   all_diff;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        rawq.push_back(sw_raw);
        obs = rawq.pop_front();
        obsq.push_back(obs);
        if (obsq.size() > DB) void'(obsq.pop_front());
        rose_m = '0;
        fell_m = '0;
        if (obsq.size() == DB) begin
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                foreach (obsq[j]) if (obsq[j][b] == clean_m[b]) all_diff = 1'b0;
                if (all_diff) begin
                    clean_m[b] = ~clean_m[b];
                    if (EDGE_EN) begin
                        if (clean_m[b]) rose_m[b] = 1'b1;
                        else            fell_m[b] = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        vec_t exp_c, exp_r;
        RESET_N = 1'b0;
        sw_raw  = '1;
        model_reset();
        repeat (3) step();
        n_vec++;
        if ({SW_CLEAN, SW_ROSE, SW_FELL} !== {3*W{1'b0}}) begin
            n_bad++;
            $display("FAIL reset_outputs: got clean=%b rose=%b fell=%b, expected all zero",
                     SW_CLEAN, SW_ROSE, SW_FELL);
        end
        @(negedge CLOCK_50) RESET_N = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            exp_c = (e >= DB + 1) ? '1 : '0;
            exp_r = (EDGE_EN && e == DB + 1) ? '1 : '0;
            n_vec++;
            if (SW_CLEAN !== exp_c || SW_ROSE !== exp_r || SW_FELL !== '0) begin
                n_bad++;
                $display("FAIL reset_release edge %0d: got clean=%b rose=%b fell=%b, expected clean=%b rose=%b fell=000000",
                         e, SW_CLEAN, SW_ROSE, SW_FELL, exp_c, exp_r);
            end
        end
    endtask

    task automatic test_single_rise();
        vec_t exp_c, exp_r;
        // Settle to only bit 4 high so bit 2 starts low
        @(negedge CLOCK_50);
        sw_raw = '0;
        sw_raw[4] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_vec++;
            if ({SW_CLEAN, SW_ROSE, SW_FELL} !== {clean_m, rose_m, fell_m}) begin
                n_bad++;
                $display("FAIL settle_model cyc %0d: got %b/%b/%b, expected %b/%b/%b",
                         c, SW_CLEAN, SW_ROSE, SW_FELL, clean_m, rose_m, fell_m);
            end
        end
        @(negedge CLOCK_50) sw_raw[2] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            exp_c = '0;
            exp_c[4] = 1'b1;
            exp_c[2] = (e >= DB + 1);
            exp_r = '0;
            exp_r[2] = EDGE_EN && (e == DB + 1);
            n_vec++;
            if (SW_CLEAN !== exp_c || SW_ROSE !== exp_r || SW_FELL !== '0) begin
                n_bad++;
                $display("FAIL single_rise edge %0d: got clean=%b rose=%b fell=%b, expected clean=%b rose=%b fell=000000",
                         e, SW_CLEAN, SW_ROSE, SW_FELL, exp_c, exp_r);
            end
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 48; c++) begin
            @(negedge CLOCK_50);
            if (c < 40) begin
                if (c % 3 == 0) sw_raw[0] = ~sw_raw[0];
            end else begin
                sw_raw[0] = 1'b0;
            end
            step();
            n_vec++;
            if (SW_CLEAN[0] !== 1'b0 || SW_ROSE[0] !== 1'b0 || SW_FELL[0] !== 1'b0 ||
                {SW_CLEAN, SW_ROSE, SW_FELL} !== {clean_m, rose_m, fell_m}) begin
                n_bad++;
                $display("FAIL bounce cyc %0d: got clean=%b rose=%b fell=%b, expected clean=%b rose=%b fell=%b",
                         c, SW_CLEAN, SW_ROSE, SW_FELL, clean_m, rose_m, fell_m);
            end
        end
    endtask

    task automatic test_simultaneous();
        vec_t exp_c, exp_r, exp_f;
        @(negedge CLOCK_50);
        sw_raw[1] = 1'b1;
        sw_raw[4] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            exp_c = '0;
            exp_c[2] = 1'b1;
            exp_c[1] = (e >= DB + 1);
            exp_c[4] = (e <  DB + 1);
            exp_r = '0;
            exp_f = '0;
            exp_r[1] = EDGE_EN && (e == DB + 1);
            exp_f[4] = EDGE_EN && (e == DB + 1);
            n_vec++;
            if (SW_CLEAN !== exp_c || SW_ROSE !== exp_r || SW_FELL !== exp_f) begin
                n_bad++;
                $display("FAIL simultaneous edge %0d: got clean=%b rose=%b fell=%b, expected clean=%b rose=%b fell=%b",
                         e, SW_CLEAN, SW_ROSE, SW_FELL, exp_c, exp_r, exp_f);
            end
        end
    endtask

    task automatic test_reset_pending();
        vec_t exp_c, exp_r;
        @(negedge CLOCK_50) sw_raw[3] = 1'b1;
        repeat (4) step();
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({SW_CLEAN, SW_ROSE, SW_FELL} !== {3*W{1'b0}}) begin
            n_bad++;
            $display("FAIL reset_async: got clean=%b rose=%b fell=%b, expected all zero",
                     SW_CLEAN, SW_ROSE, SW_FELL);
        end
        repeat (2) step();
        @(negedge CLOCK_50) RESET_N = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            exp_c = '0;
            exp_r = '0;
            for (int b = 1; b <= 3; b++) begin
                exp_c[b] = (e >= DB + 1);
                exp_r[b] = EDGE_EN && (e == DB + 1);
            end
            n_vec++;
            if (SW_CLEAN !== exp_c || SW_ROSE !== exp_r || SW_FELL !== '0) begin
                n_bad++;
                $display("FAIL reset_pending edge %0d: got clean=%b rose=%b fell=%b, expected clean=%b rose=%b fell=000000",
                         e, SW_CLEAN, SW_ROSE, SW_FELL, exp_c, exp_r);
            end
        end
    endtask

    task automatic test_random();
        int hold [W];
        foreach (hold[b]) hold[b] = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLOCK_50);
            for (int b = 0; b < W; b++) begin
                if (hold[b] == 0) begin
                    sw_raw[b] = 1'($urandom_range(0, 1));
                    hold[b]   = $urandom_range(1, 9);
                end else begin
                    hold[b]--;
                end
            end
            step();
            n_vec++;
            if ({SW_CLEAN, SW_ROSE, SW_FELL} !== {clean_m, rose_m, fell_m} ||
                (SW_ROSE & SW_FELL) !== '0) begin
                n_bad++;
                $display("FAIL random cyc %0d: got clean=%b rose=%b fell=%b, expected clean=%b rose=%b fell=%b",
                         c, SW_CLEAN, SW_ROSE, SW_FELL, clean_m, rose_m, fell_m);
            end
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        sw_raw  = '0;
        model_reset();
        test_reset();
        test_single_rise();
        test_bounce();
        test_simultaneous();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
